// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encodings and score width for the pong game sequencer
package pong_pkg;
  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_POINT  = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  typedef logic [SCORE_W-1:0] score_t;
endpackage

// File: rtl/pong_tick_gen.sv
// rtl/pong_tick_gen.sv - free-running game tick divider, tick high on the last count
module pong_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CW'(TICK_DIV - 1));
endmodule

// File: rtl/pong_game_sequencer.sv
// rtl/pong_game_sequencer.sv - pong game FSM: serve/play/pause/point/over sequencing and scoring
module pong_game_sequencer
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_step,
  output logic               paddle_step,
  output logic               ball_center,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         game_state,
  output logic               winner
);
  localparam int     SC_W = $clog2(SERVE_TICKS + 1);
  localparam score_t WIN  = score_t'(WIN_SCORE);

  state_t          state, state_n;
  logic            origin_play, origin_play_n;
  logic [SC_W-1:0] serve_cnt, serve_cnt_n, serve_inc;
  score_t          sl_n, sr_n;
  logic            dir_n, win_n, ball_n, paddle_n, center_n;
  logic            start_q, start_armed, start_rise, tick;

  pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // start must be seen low after reset before a rising edge can count
  assign start_rise = start & ~start_q & start_armed;
  assign serve_inc  = serve_cnt + 1'b1;
  assign game_state = state;

  always_comb begin
    state_n       = state;
    origin_play_n = origin_play;
    serve_cnt_n   = serve_cnt;
    sl_n          = score_l;
    sr_n          = score_r;
    dir_n         = serve_dir;
    win_n         = winner;
    ball_n        = 1'b0;
    paddle_n      = 1'b0;
    center_n      = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_n     = ST_SERVE;
          sl_n        = '0;
          sr_n        = '0;
          dir_n       = 1'b1;
          center_n    = 1'b1;
          serve_cnt_n = '0;
        end
      end
      ST_SERVE: begin
        if (pause) begin
          state_n       = ST_PAUSED;
          origin_play_n = 1'b0;
        end else if (tick) begin
          paddle_n    = 1'b1;
          serve_cnt_n = serve_inc;
          if (serve_inc == SC_W'(SERVE_TICKS)) state_n = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // a miss wins over both pause and the tick landing in the same cycle
        if (miss_left || miss_right) begin
          state_n = ST_POINT;
          if (miss_left && !miss_right) begin
            if (score_r != WIN) sr_n = score_r + 1'b1;
            dir_n = 1'b0;
          end else if (miss_right && !miss_left) begin
            if (score_l != WIN) sl_n = score_l + 1'b1;
            dir_n = 1'b1;
          end
        end else if (pause) begin
          state_n       = ST_PAUSED;
          origin_play_n = 1'b1;
        end else if (tick) begin
          ball_n   = 1'b1;
          paddle_n = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (!pause) state_n = origin_play ? ST_PLAY : ST_SERVE;
      end
      ST_POINT: begin
        if (score_l == WIN || score_r == WIN) begin
          state_n = ST_OVER;
          win_n   = (score_r == WIN);
        end else begin
          state_n     = ST_SERVE;
          center_n    = 1'b1;
          serve_cnt_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      origin_play <= 1'b0;
      serve_cnt   <= '0;
      score_l     <= '0;
      score_r     <= '0;
      serve_dir   <= 1'b1;
      winner      <= 1'b0;
      ball_step   <= 1'b0;
      paddle_step <= 1'b0;
      ball_center <= 1'b0;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      state       <= state_n;
      origin_play <= origin_play_n;
      serve_cnt   <= serve_cnt_n;
      score_l     <= sl_n;
      score_r     <= sr_n;
      serve_dir   <= dir_n;
      winner      <= win_n;
      ball_step   <= ball_n;
      paddle_step <= paddle_n;
      ball_center <= center_n;
      start_q     <= start;
      start_armed <= start_armed | ~start;
    end
  end
endmodule

// File: doc/pong_game_sequencer.md
PONG_GAME_SEQUENCER -- requirements
Module: pong_game_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per game tick (>=2).
REQ-002 SHALL have parameter SERVE_TICKS, default 60, game ticks held in SERVE before play (>=1).
REQ-003 SHALL have parameter WIN_SCORE, default 7, points ending a game (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  level; rising edge begins a game.
REQ-007 SHALL have port pause  input  1  level; high freezes play.
REQ-008 SHALL have port miss_left  input  1  one-cycle pulse: ball passed left edge.
REQ-009 SHALL have port miss_right  input  1  one-cycle pulse: ball passed right edge.
REQ-010 SHALL have port ball_step  output  1  one-cycle enable: ball datapath advances one step.
REQ-011 SHALL have port paddle_step  output  1  one-cycle enable: paddle datapath samples buttons and moves.
REQ-012 SHALL have port ball_center  output  1  one-cycle pulse: ball datapath reloads centre position.
REQ-013 SHALL have port serve_dir  output  1  initial ball x-direction, 1=right.
REQ-014 SHALL have ports score_l, score_r  output  4 each  points per player.
REQ-015 SHALL have port game_state  output  3  current FSM state encoding.
REQ-016 SHALL have port winner  output  1  valid in OVER: 1=right, 0=left.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 and wrap, running in all states; tick is internal, high the cycle count==TICK_DIV-1.
REQ-018 All outputs SHALL be registered; steps and ball_center SHALL appear the cycle after their causing event, high exactly one cycle.
REQ-019 start SHALL be edge-detected through a registered previous-value; level-held start SHALL not retrigger.
REQ-020 States SHALL be IDLE, SERVE, PLAY, PAUSED, POINT, OVER.
REQ-021 IDLE or OVER + start rising edge -> SERVE; SHALL clear scores, set serve_dir=1, pulse ball_center, clear serve count.
REQ-022 SERVE: each tick SHALL pulse paddle_step only and increment serve count; on the tick making count==SERVE_TICKS -> PLAY.
REQ-023 PLAY: each tick SHALL pulse ball_step and paddle_step in the same cycle.
REQ-024 PLAY + miss_left alone -> POINT, score_r+1, serve_dir=0; miss_right alone -> POINT, score_l+1, serve_dir=1.
REQ-025 PLAY + miss_left and miss_right same cycle -> POINT, no score change, serve_dir unchanged.
REQ-026 Miss on the same cycle as tick SHALL take priority: no step pulses issued that tick.
REQ-027 miss inputs SHALL be ignored outside PLAY.
REQ-028 POINT (one cycle): any score==WIN_SCORE -> OVER; else -> SERVE with ball_center pulse, serve count cleared.
REQ-029 Scores SHALL never exceed WIN_SCORE.
REQ-030 SERVE or PLAY + pause high -> PAUSED, remembering origin state; serve count retained; no steps while PAUSED.
REQ-031 PAUSED + pause low -> origin state; pause SHALL outrank tick in the same cycle; miss outranks pause in PLAY.
REQ-032 OVER: winner SHALL be 1 iff score_r==WIN_SCORE; scores held.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, tick and serve counts 0, scores 0, serve_dir=1, winner=0, all pulses 0, start edge register 0.
REQ-034 Reset mid-game SHALL discard origin-state memory; start held high through reset release SHALL not start a game.

Structure
REQ-035 State encodings (IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, OVER=5) and score width SHALL live in shared package pong_pkg.
REQ-036 Tick generator SHALL be sub-module pong_tick_gen (parameter TICK_DIV, output tick); FSM and scoring stay in top.

Verification (TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=3)
REQ-037 Reset release, start 0->1 -> ball_center one cycle, SERVE; 2 ticks (8 clk) with paddle_step only -> PLAY; ball_step every 4 clk.
REQ-038 PLAY, miss_left pulse -> score_r=1, serve_dir=0, POINT one cycle, ball_center, SERVE.
REQ-039 miss_left and miss_right same cycle -> scores unchanged, serve_dir unchanged, back to SERVE.
REQ-040 pause high 10 clk in PLAY -> no steps, game_state=3; pause low -> PLAY, ball_step resumes on next tick.
REQ-041 three miss_left -> score_r=3, OVER, winner=1; further misses ignored; start edge -> scores 0, SERVE.
REQ-042 rst_n low mid-PLAY with start held high -> IDLE, all outputs reset; no game until start falls and rises.
